fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the combinational instruction_memory. Owns the PC,
//  drives the memory byte address and captures fetched words into a 2-entry fetch
//  buffer with a valid/ready handshake toward decode. Accepts branch/jump redirects
//  from execute and halts on an all-zero word (end of program image).
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  2              fetch buffer entries (power of two, >=2)
//  MEM_SIZE    1024           instruction memory size in bytes; sets imem_addr_o width
// PORTS
//  clk_i            in   1                  clock, rising edge
//  rst_i            in   1                  synchronous reset, active-high
//  enable_i         in   1                  fetch enable; 0 = no new fetches
//  imem_addr_o      out  $clog2(MEM_SIZE)   byte address to instruction_memory (pc[AW-1:0])
//  imem_inst_i      in   INST_WIDTH         word from instruction_memory, same cycle
//  redirect_i       in   1                  flush buffer and load redirect_pc_i
//  redirect_pc_i    in   32                 redirect target
//  inst_valid_o     out  1                  buffer head valid
//  inst_ready_i     in   1                  decode accepts head
//  inst_o           out  INST_WIDTH         head instruction
//  pc_o             out  32                 PC of head instruction
//  halt_o           out  1                  1 while in HALT
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pc<=RESET_PC, buffer emptied, state<=IDLE;
//    inst_valid_o=0, inst_o=0, pc_o=0, halt_o=0. Reset mid-operation discards buffer.
//  - FSM states: IDLE, FETCH, HALT.
//    IDLE -> FETCH when enable_i=1. FETCH -> IDLE when enable_i=0 (buffer kept).
//    FETCH -> HALT when fetched word == 0 is sampled (word not pushed, pc not advanced).
//    HALT -> FETCH only on redirect_i. Any state: redirect_i applies as below.
//  - imem_addr_o = pc[AW-1:0] combinationally, all states. Memory is async-read, so a
//    word is fetched in the same cycle its address is driven; push latency 1 clock,
//    first inst_valid_o one cycle after entering FETCH.
//  - Push in FETCH: if (not full OR pop this cycle) and word != 0: write {pc, word},
//    pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC+4 -> 0). Full without pop: pc held, no push.
//  - Pop: inst_valid_o & inst_ready_i. Simultaneous push+pop on full buffer is allowed;
//    count unchanged. Empty: pop ignored. inst_o/pc_o show head, 0 when empty.
//  - Redirect (highest priority): same edge flushes buffer (count<=0), pc<=redirect_pc_i,
//    no push or pop counted that cycle, HALT/IDLE->FETCH if enable_i=1 else IDLE.
//    redirect_pc_i[1:0] ignored (forced 00) unless FETCH_MISALIGN_CHK_EN.
//  - Buffer: circular, rd/wr pointers log2(FIFO_DEPTH) bits wrap; count 0..FIFO_DEPTH.
//  - halt_o = (state==HALT), registered. Buffer drains normally while halted.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: adds output misalign_o (1 bit). Redirect with
//   redirect_pc_i[1:0]!=0 sets misalign_o=1 (sticky until reset), state<=HALT, flush,
//   pc unchanged. Not defined: no port, low bits masked, fetch continues at target&~3.
// STRUCTURE
//  - pkg_config: INST_WIDTH (existing); add fetch_state_e {IDLE,FETCH,HALT},
//    RESET_PC_DEFAULT, INST_ZERO = 32'h0000_0000.
//  - One sub-module: fetch_fifo (parametric sync FIFO, {pc,inst} entries, flush input).
// TESTING
//  - Reset, enable_i=1, ready=1, image 00108113,00108193,00310233,fe218ae3,00000000 ->
//    4 handshakes, pc_o 0,4,8,C in order; halt_o=1 after word at 0x10; no 5th valid.
//  - inst_ready_i=0 for 5 cycles -> buffer holds 2 entries (pc 0,4), imem_addr_o stays 8;
//    release -> 00310233 delivered after the first two, no loss or duplicate.
//  - redirect_i with target 0x4 while buffer full -> next valid is 00108193 at pc_o=4;
//    stale entries never appear.
//  - In HALT, redirect to 0x0 -> FETCH resumes, 00108113 valid next cycle; halt_o=0.
//  - Assert rst_i mid-stream with 2 entries buffered -> next cycle valid=0, addr=0.
//  - FETCH_MISALIGN_CHK_EN: redirect to 0x6 -> misalign_o=1, halt_o=1, no valid;
//    undefined: redirect to 0x6 -> fetch at 0x4, 00108193 delivered.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_ctrl_pkg;

    localparam int INST_WIDTH = 32;

    localparam logic [31:0]           RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] INST_ZERO        = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// rtl/fetch_ctrl_fifo.sv - fetch_fifo: parametric synchronous FIFO with flush for {pc, inst} entries
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active-high; empties the FIFO
//   flush - synchronous flush; empties the FIFO, ignores push/pop that cycle
//   push  - write push_data (dropped if full and no pop this cycle)
//   pop   - advance head (ignored when empty)
//   empty - no entries held
//   full  - DEPTH entries held
//   head  - oldest entry, zero when empty
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic pop_eff;
    logic push_eff;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_eff  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_eff = push && (!full || pop_eff);
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, async imem address, 2-entry fetch buffer, redirect and halt
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN (adds misalign_o; misaligned redirect halts).
//
// Ports:
//   clk_i         - clock, rising edge
//   rst_i         - synchronous reset, active-high
//   enable_i      - fetch enable; 0 stops new fetches
//   imem_addr_o   - byte address to instruction memory (pc low bits)
//   imem_inst_i   - word returned by instruction memory in the same cycle
//   redirect_i    - flush buffer and jump to redirect_pc_i
//   redirect_pc_i - redirect target
//   inst_valid_o  - buffer head valid
//   inst_ready_i  - decode accepts head
//   inst_o        - head instruction (0 when empty)
//   pc_o          - PC of head instruction (0 when empty)
//   misalign_o    - sticky misaligned-redirect flag (FETCH_MISALIGN_CHK_EN only)
//   halt_o        - 1 while halted on an all-zero word or misaligned redirect
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MEM_SIZE   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    output logic [$clog2(MEM_SIZE)-1:0] imem_addr_o,
    input  logic [INST_WIDTH-1:0]       imem_inst_i,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_pc_i,
    output logic                        inst_valid_o,
    input  logic                        inst_ready_i,
    output logic [INST_WIDTH-1:0]       inst_o,
    output logic [31:0]                 pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic                        misalign_o,
`endif
    output logic                        halt_o
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int EW = 32 + INST_WIDTH;

    fetch_state_e state;
    logic [31:0]  pc;

    logic          fifo_empty;
    logic          fifo_full;
    logic [EW-1:0] fifo_head;
    logic          word_zero;
    logic          pop;
    logic          fetching;
    logic          push;

    assign imem_addr_o = pc[AW-1:0];
    assign word_zero   = (imem_inst_i == INST_ZERO);

    // Redirect owns the cycle: nothing enters or leaves the buffer.
    assign pop      = inst_valid_o && inst_ready_i && !redirect_i;
    assign fetching = (state == FETCH) && enable_i && !redirect_i;
    assign push     = fetching && !word_zero && (!fifo_full || pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({pc, imem_inst_i}),
        .pop       (pop),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (fifo_head)
    );

    assign inst_valid_o = !fifo_empty;
    assign pc_o         = fifo_head[EW-1:INST_WIDTH];
    assign inst_o       = fifo_head[INST_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            halt_o <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_o <= 1'b0;
`endif
        end else if (redirect_i) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc_i[1:0] != 2'b00) begin
                // Keep the old pc so the faulting context is not lost.
                misalign_o <= 1'b1;
                state      <= HALT;
                halt_o     <= 1'b1;
            end else begin
                pc     <= redirect_pc_i;
                state  <= enable_i ? FETCH : IDLE;
                halt_o <= 1'b0;
            end
`else
            pc     <= redirect_pc_i & ~32'd3;
            state  <= enable_i ? FETCH : IDLE;
            halt_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (word_zero) begin
                        // End of image: word dropped, pc parked on it.
                        state  <= HALT;
                        halt_o <= 1'b1;
                    end else if (push) begin
                        pc <= pc + 32'd4;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= IDLE;
                    halt_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
